// File: rtl/square_sum_cal.sv
// Frame-based |z|^2 calculator: three-stage pipeline (register, square, sum) with a
// frame-tracking FSM that gates input acceptance and flags the last output of each frame.
module square_sum_cal #(
    parameter int unsigned FRAME_LENGTH = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [70:0]  dataInRe,
    input  logic signed [70:0]  dataInIm,
    output logic        [141:0] dataOut,
    output logic                dataValid,
    output logic                frameDone,
    output logic                busy
);

    localparam logic [15:0] FrameLast = 16'(FRAME_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} stateType;

    stateType stateQ, stateD;
    logic [15:0] inCountQ, inCountD;
    logic [15:0] outCountQ, outCountD;

    logic                s1ValidQ;
    logic signed [70:0]  s1ReQ, s1ImQ;
    logic                s2ValidQ;
    logic        [140:0] s2SqReQ, s2SqImQ;
    logic                s3ValidQ;
    logic        [141:0] s3SumQ;

    logic         accept;
    logic         lastIn;
    logic [70:0]  absRe, absIm;
    logic [140:0] wideRe, wideIm;
    logic [140:0] sqReD, sqImD;
    logic [141:0] sumD;

    // Samples arriving while the frame drains are dropped before entering the pipeline.
    assign accept    = enable && (stateQ != StDrain);
    assign lastIn    = (inCountQ == FrameLast);
    assign frameDone = s3ValidQ && (outCountQ == FrameLast);
    assign busy      = (stateQ != StIdle);
    assign dataValid = s3ValidQ;
    assign dataOut   = s3SumQ;

    // Squaring the magnitude keeps the product unsigned; |-2^70| = 2^70 fits in 71 bits.
    assign absRe  = s1ReQ[70] ? $unsigned(-s1ReQ) : $unsigned(s1ReQ);
    assign absIm  = s1ImQ[70] ? $unsigned(-s1ImQ) : $unsigned(s1ImQ);
    assign wideRe = {70'd0, absRe};
    assign wideIm = {70'd0, absIm};
    assign sqReD  = wideRe * wideRe;
    assign sqImD  = wideIm * wideIm;
    assign sumD   = {1'b0, s2SqReQ} + {1'b0, s2SqImQ};

    always_comb begin
        stateD    = stateQ;
        inCountD  = inCountQ;
        outCountD = outCountQ;

        if (accept) begin
            inCountD = inCountQ + 16'd1;
        end
        if (s3ValidQ) begin
            outCountD = outCountQ + 16'd1;
        end

        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD = lastIn ? StDrain : StRun;
                end
            end
            StRun: begin
                if (accept && lastIn) begin
                    stateD = StDrain;
                end
            end
            StDrain: begin
                if (frameDone) begin
                    stateD    = StIdle;
                    inCountD  = '0;
                    outCountD = '0;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ    <= StIdle;
            inCountQ  <= '0;
            outCountQ <= '0;
        end else begin
            stateQ    <= stateD;
            inCountQ  <= inCountD;
            outCountQ <= outCountD;
        end
    end

    // Data registers are zeroed on bubbles so dataOut reads 0 whenever dataValid is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1ValidQ <= 1'b0;
            s1ReQ    <= '0;
            s1ImQ    <= '0;
            s2ValidQ <= 1'b0;
            s2SqReQ  <= '0;
            s2SqImQ  <= '0;
            s3ValidQ <= 1'b0;
            s3SumQ   <= '0;
        end else begin
            s1ValidQ <= accept;
            s1ReQ    <= accept ? dataInRe : '0;
            s1ImQ    <= accept ? dataInIm : '0;
            s2ValidQ <= s1ValidQ;
            s2SqReQ  <= s1ValidQ ? sqReD : '0;
            s2SqImQ  <= s1ValidQ ? sqImD : '0;
            s3ValidQ <= s2ValidQ;
            s3SumQ   <= s2ValidQ ? sumD : '0;
        end
    end

endmodule
